// File: rtl/slv_guard_rst_ctrl.sv
// slv_guard_rst_ctrl: recovery sequencer from slave-guard timeout to subordinate reset and reopen.
// Optional SLV_GUARD_RST_CTRL_AUTO_RETRY_EN re-runs recovery while the guard request persists.
module slv_guard_rst_ctrl #(
  parameter int unsigned RstPulseCycles = 16,
  parameter int unsigned AckTimeout     = 1024,
  parameter int unsigned HoldOffCycles  = 8,
  parameter int unsigned MaxRetries     = 3,
  parameter int unsigned CntWidth       = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ctrl_en_i,
  input  logic                guard_rst_req_i,
  input  logic                rst_stat_i,
  input  logic                irq_clr_i,
  output logic                isolate_o,
  output logic                slv_rst_req_o,
  output logic                guard_clear_o,
  output logic                irq_o,
  output logic                fatal_o,
  output logic [CntWidth-1:0] recover_cnt_o
);
  localparam int unsigned MaxA = RstPulseCycles > AckTimeout ? RstPulseCycles : AckTimeout;
  localparam int unsigned MaxC = MaxA > HoldOffCycles ? MaxA : HoldOffCycles;
  localparam int unsigned TW   = $clog2(MaxC + 1);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RESET    = 3'd1;
  localparam logic [2:0] WAIT_REL = 3'd2;
  localparam logic [2:0] HOLDOFF  = 3'd3;
  localparam logic [2:0] FATAL    = 3'd4;
  logic [2:0]          state_q, state_d;
  logic [TW-1:0]       pulse_q, pulse_d, ack_q, ack_d, hold_q, hold_d;
  logic                trig;
  logic                pulse_done;
  logic                isolate_d, slv_rst_req_d, guard_clear_d, irq_d, fatal_d;
  logic [CntWidth-1:0] recover_d;
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
  localparam int unsigned RW = $clog2(MaxRetries + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif
  assign pulse_done = pulse_q == TW'(RstPulseCycles);
  // ack/hold counters start at 1 on entry so a state lasts exactly the parameter in cycles
  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    ack_d   = ack_q;
    hold_d  = hold_q;
    trig    = 1'b0;
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: begin
        pulse_d = '0;
        ack_d   = TW'(1);
        if (guard_rst_req_i && ctrl_en_i) begin
          state_d = RESET;
          trig    = 1'b1;
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
          retry_d = RW'(1);
`endif
        end
      end
      RESET: begin
        pulse_d = pulse_done ? pulse_q : pulse_q + 1'b1;
        if (pulse_done && rst_stat_i) begin
          state_d = WAIT_REL;
          ack_d   = TW'(1);
        end else if (ack_q == TW'(AckTimeout)) state_d = FATAL;
        else ack_d = ack_q + 1'b1;
      end
      WAIT_REL: begin
        hold_d = TW'(1);
        if (!rst_stat_i) state_d = HOLDOFF;
        else if (ack_q == TW'(AckTimeout)) state_d = FATAL;
        else ack_d = ack_q + 1'b1;
      end
      HOLDOFF: begin
        pulse_d = '0;
        ack_d   = TW'(1);
        if (hold_q != TW'(HoldOffCycles)) hold_d = hold_q + 1'b1;
        else if (!guard_rst_req_i) begin
          state_d = IDLE;
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
          retry_d = '0;
`endif
        end else begin
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
          if (retry_q == RW'(MaxRetries)) state_d = FATAL;
          else begin
            state_d = RESET;
            trig    = 1'b1;
            retry_d = retry_q + 1'b1;
          end
`else
          state_d = FATAL;
`endif
        end
      end
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end
  assign isolate_d     = state_d != IDLE;
  assign slv_rst_req_d = state_d == RESET || state_d == FATAL;
  assign guard_clear_d = state_q == WAIT_REL && state_d == HOLDOFF;
  assign fatal_d       = state_d == FATAL;
  assign irq_d         = trig ? 1'b1 : irq_clr_i ? 1'b0 : irq_o;
  assign recover_d     = trig && recover_cnt_o != '1 ? recover_cnt_o + 1'b1 : recover_cnt_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pulse_q       <= '0;
      ack_q         <= '0;
      hold_q        <= '0;
      isolate_o     <= 1'b0;
      slv_rst_req_o <= 1'b0;
      guard_clear_o <= 1'b0;
      irq_o         <= 1'b0;
      fatal_o       <= 1'b0;
      recover_cnt_o <= '0;
    end else begin
      state_q       <= state_d;
      pulse_q       <= pulse_d;
      ack_q         <= ack_d;
      hold_q        <= hold_d;
      isolate_o     <= isolate_d;
      slv_rst_req_o <= slv_rst_req_d;
      guard_clear_o <= guard_clear_d;
      irq_o         <= irq_d;
      fatal_o       <= fatal_d;
      recover_cnt_o <= recover_d;
    end
  end
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) retry_q <= '0;
    else retry_q <= retry_d;
  end
`endif
endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// tb_slv_guard_rst_ctrl: directed checks of the guard reset sequencer with small timing parameters.
module tb_slv_guard_rst_ctrl;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic ctrl_en_i = 1'b0, guard_rst_req_i = 1'b0, rst_stat_i = 1'b0, irq_clr_i = 1'b0;
  logic isolate_o, slv_rst_req_o, guard_clear_o, irq_o, fatal_o;
  logic [1:0] recover_cnt_o;
  logic [3:0] sig;
  int errs = 0, checks = 0;
  slv_guard_rst_ctrl #(
    .RstPulseCycles(4), .AckTimeout(16), .HoldOffCycles(3), .MaxRetries(2), .CntWidth(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_en_i(ctrl_en_i), .guard_rst_req_i(guard_rst_req_i),
    .rst_stat_i(rst_stat_i), .irq_clr_i(irq_clr_i), .isolate_o(isolate_o),
    .slv_rst_req_o(slv_rst_req_o), .guard_clear_o(guard_clear_o), .irq_o(irq_o),
    .fatal_o(fatal_o), .recover_cnt_o(recover_cnt_o)
  );
  assign sig = {isolate_o, slv_rst_req_o, guard_clear_o, fatal_o};
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic apply_reset;
    rst_ni = 1'b0;
    ctrl_en_i = 1'b1;
    guard_rst_req_i = 1'b0;
    rst_stat_i = 1'b0;
    irq_clr_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rst_ni = 1'b0;
    tick();
    checks++;
    if ({sig, irq_o, recover_cnt_o} !== 7'b0) begin
      errs++;
      $display("FAIL reset_values got=%b exp=%b", {sig, irq_o, recover_cnt_o}, 7'b0);
    end
    rst_ni = 1'b1;
    ctrl_en_i = 1'b1;
    guard_rst_req_i = 1'b1;
    tick();
    guard_rst_req_i = 1'b0;
    tick();
    tick();
    checks++;
    if (sig !== 4'b1100) begin
      errs++;
      $display("FAIL mid_reset_state got=%b exp=%b", sig, 4'b1100);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({sig, irq_o, recover_cnt_o} !== 7'b0) begin
      errs++;
      $display("FAIL async_reset got=%b exp=%b", {sig, irq_o, recover_cnt_o}, 7'b0);
    end
    tick();
    rst_ni = 1'b1;
    guard_rst_req_i = 1'b1;
    tick();
    guard_rst_req_i = 1'b0;
    checks++;
    if ({sig, irq_o, recover_cnt_o} !== 7'b1100_1_01) begin
      errs++;
      $display("FAIL restart_after_reset got=%b exp=%b", {sig, irq_o, recover_cnt_o}, 7'b1100_1_01);
    end
  endtask
  task automatic test_ignore;
    apply_reset();
    ctrl_en_i = 1'b0;
    guard_rst_req_i = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sig, recover_cnt_o} !== 6'b0) begin
      errs++;
      $display("FAIL disabled_ignore got=%b exp=%b", {sig, recover_cnt_o}, 6'b0);
    end
    guard_rst_req_i = 1'b0;
    ctrl_en_i = 1'b1;
    rst_stat_i = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sig, irq_o} !== 5'b0) begin
      errs++;
      $display("FAIL idle_stat_ignore got=%b exp=%b", {sig, irq_o}, 5'b0);
    end
    rst_stat_i = 1'b0;
  endtask
  task automatic test_nominal;
    logic [3:0] exp;
    apply_reset();
    guard_rst_req_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      guard_rst_req_i = 1'b0;
      rst_stat_i = k >= 2 && k < 10;
      exp = {k <= 13, k <= 5, k == 11, 1'b0};
      checks++;
      if (sig !== exp) begin
        errs++;
        $display("FAIL nominal_t%0d got=%b exp=%b", k, sig, exp);
      end
    end
    checks++;
    if ({irq_o, recover_cnt_o} !== 3'b1_01) begin
      errs++;
      $display("FAIL nominal_irq_cnt got=%b exp=%b", {irq_o, recover_cnt_o}, 3'b1_01);
    end
  endtask
  task automatic test_irq;
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0) begin
      errs++;
      $display("FAIL irq_clear got=%b exp=0", irq_o);
    end
    guard_rst_req_i = 1'b1;
    irq_clr_i = 1'b1;
    tick();
    guard_rst_req_i = 1'b0;
    irq_clr_i = 1'b0;
    checks++;
    if ({irq_o, recover_cnt_o} !== 3'b1_10) begin
      errs++;
      $display("FAIL irq_set_priority got=%b exp=%b", {irq_o, recover_cnt_o}, 3'b1_10);
    end
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0) begin
      errs++;
      $display("FAIL irq_clear_alone got=%b exp=0", irq_o);
    end
  endtask
  task automatic test_ack_timeout;
    apply_reset();
    guard_rst_req_i = 1'b1;
    tick();
    guard_rst_req_i = 1'b0;
    repeat (15) tick();
    checks++;
    if (sig !== 4'b1100) begin
      errs++;
      $display("FAIL ack_before_timeout got=%b exp=%b", sig, 4'b1100);
    end
    tick();
    checks++;
    if (sig !== 4'b1101) begin
      errs++;
      $display("FAIL ack_timeout_fatal got=%b exp=%b", sig, 4'b1101);
    end
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    checks++;
    if ({irq_o, fatal_o} !== 2'b01) begin
      errs++;
      $display("FAIL fatal_vs_irq_clr got=%b exp=%b", {irq_o, fatal_o}, 2'b01);
    end
    guard_rst_req_i = 1'b1;
    rst_stat_i = 1'b1;
    ctrl_en_i = 1'b0;
    repeat (3) tick();
    rst_stat_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sig, recover_cnt_o} !== 6'b1101_01) begin
      errs++;
      $display("FAIL fatal_sticky got=%b exp=%b", {sig, recover_cnt_o}, 6'b1101_01);
    end
  endtask
  task automatic test_rel_timeout;
    apply_reset();
    guard_rst_req_i = 1'b1;
    tick();
    guard_rst_req_i = 1'b0;
    rst_stat_i = 1'b1;
    repeat (20) tick();
    checks++;
    if (sig !== 4'b1000) begin
      errs++;
      $display("FAIL rel_before_timeout got=%b exp=%b", sig, 4'b1000);
    end
    tick();
    checks++;
    if (sig !== 4'b1101) begin
      errs++;
      $display("FAIL rel_timeout_fatal got=%b exp=%b", sig, 4'b1101);
    end
    rst_stat_i = 1'b0;
  endtask
  task automatic test_persistent;
    int n, gc, exp_n, exp_cnt;
    bit hit;
`ifdef SLV_GUARD_RST_CTRL_AUTO_RETRY_EN
    exp_n = 19;
    exp_cnt = 2;
`else
    exp_n = 10;
    exp_cnt = 1;
`endif
    apply_reset();
    guard_rst_req_i = 1'b1;
    n = 0;
    gc = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      tick();
      n++;
      rst_stat_i = slv_rst_req_o;
      if (guard_clear_o) gc++;
      if (fatal_o) hit = 1'b1;
    end
    checks++;
    if (n !== exp_n) begin
      errs++;
      $display("FAIL persist_fatal_cycle got=%0d exp=%0d", n, exp_n);
    end
    checks++;
    if (recover_cnt_o !== 2'(exp_cnt)) begin
      errs++;
      $display("FAIL persist_recover_cnt got=%0d exp=%0d", recover_cnt_o, exp_cnt);
    end
    checks++;
    if (gc !== exp_cnt) begin
      errs++;
      $display("FAIL persist_clear_pulses got=%0d exp=%0d", gc, exp_cnt);
    end
    guard_rst_req_i = 1'b0;
    rst_stat_i = 1'b0;
  endtask
  task automatic test_saturation;
    int n;
    apply_reset();
    for (int s = 1; s <= 4; s++) begin
      guard_rst_req_i = 1'b1;
      tick();
      guard_rst_req_i = 1'b0;
      n = 0;
      while (isolate_o && n < 40) begin
        rst_stat_i = slv_rst_req_o;
        tick();
        n++;
      end
      checks++;
      if (n !== 9) begin
        errs++;
        $display("FAIL sat_seq%0d_length got=%0d exp=9", s, n);
      end
    end
    checks++;
    if (recover_cnt_o !== 2'b11) begin
      errs++;
      $display("FAIL recover_saturate got=%b exp=11", recover_cnt_o);
    end
  endtask
  initial begin
    test_reset();
    test_ignore();
    test_nominal();
    test_irq();
    test_ack_timeout();
    test_rel_timeout();
    test_persistent();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
